usb_out_ep_buffer: RTL

Single-packet OUT endpoint buffer between the USB protocol engine (rx side) and the SPI bridge endpoint consumer (out_ep_* side).
- Captures one DATA0/DATA1 payload per transaction and selects the handshake: ACK, NAK or STALL.
- Commits the payload only when the CRC is good, then presents it byte-by-byte to the consumer with 1-cycle read latency.
- Releases the buffer when the consumer has drained it.

---
 rtl/usb_ep_pkg.sv | 26 ++
 rtl/usb_ep_buffer_ram.sv | 38 +++
 rtl/usb_out_ep_buffer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB OUT endpoint buffer: state encoding,
// handshake codes and the default maximum packet size.
package usb_ep_pkg;

  localparam int MAX_PKT_SIZE_DEF = 64;

  localparam logic [1:0] ST_EMPTY      = 2'd0;
  localparam logic [1:0] ST_RX         = 2'd1;
  localparam logic [1:0] ST_FULL       = 2'd2;
  localparam logic [1:0] ST_RX_DISCARD = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY      = ST_EMPTY,
    S_RX         = ST_RX,
    S_FULL       = ST_FULL,
    S_RX_DISCARD = ST_RX_DISCARD
  } ep_state_e;

  typedef enum logic [1:0] {
    HS_NONE  = 2'd0,
    HS_ACK   = 2'd1,
    HS_NAK   = 2'd2,
    HS_STALL = 2'd3
  } hs_e;

endpackage

// File: rtl/usb_ep_buffer_ram.sv
// Packet storage for the OUT endpoint: simple dual-port RAM, synchronous
// write, synchronous read with one cycle of latency. The array itself is
// not reset; only the read data register is.
module usb_ep_buffer_ram
  import usb_ep_pkg::*;
#(
  parameter int DEPTH = MAX_PKT_SIZE_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port: store one payload byte.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered byte, held until the next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/usb_out_ep_buffer.sv
// Single-packet USB OUT endpoint buffer. Receives one DATA payload from the
// protocol engine, selects ACK/NAK/STALL, and hands committed packets to the
// endpoint consumer one byte at a time.
// Optional build macro OUT_EP_TOGGLE_CHECK_EN enables data-toggle tracking
// and duplicate-packet detection; without it the toggle is ignored.
module usb_out_ep_buffer
  import usb_ep_pkg::*;
#(
  parameter int MAX_PKT_SIZE = MAX_PKT_SIZE_DEF,
  parameter int PTR_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pkt_start,
  input  logic       rx_pid_data1,
  input  logic       rx_setup,
  input  logic       rx_data_put,
  input  logic [7:0] rx_data,
  input  logic       rx_pkt_end,
  input  logic       rx_pkt_valid,
  output logic       hs_ack,
  output logic       hs_nak,
  output logic       hs_stall,
  input  logic       out_ep_req,
  output logic       out_ep_grant,
  output logic       out_ep_data_avail,
  output logic       out_ep_setup,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  input  logic       out_ep_stall,
  output logic       out_ep_acked
);

  localparam int             RAM_AW  = $clog2(MAX_PKT_SIZE);
  localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(MAX_PKT_SIZE);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  ep_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             setup_q, setup_d;
  hs_e              hs_q, hs_d;
  logic             acked_q;

  logic ram_we, ram_re;
  logic load_rx;   // start a fresh receive (from EMPTY, restart, flush or release)
  logic commit;    // accept the received payload into FULL
  logic avail;
  logic dup;

  assign avail = (rd_ptr_q != len_q);

`ifdef OUT_EP_TOGGLE_CHECK_EN
  logic tog_q;
  logic exp_tog_q;

  assign dup = (tog_q != exp_tog_q);

  // Toggle tracking: latch the packet's PID toggle, advance the expected one on commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tog_q     <= 1'b0;
      exp_tog_q <= 1'b0;
    end else begin
      if (load_rx) begin
        tog_q <= rx_pid_data1;
      end
      if (commit) begin
        exp_tog_q <= setup_q ? 1'b1 : ~exp_tog_q;
      end
    end
  end
`else
  logic unused_tog;
  assign unused_tog = rx_pid_data1;
  assign dup        = 1'b0;
`endif

  // Next-state, pointer and handshake selection.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    setup_d  = setup_q;
    hs_d     = HS_NONE;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    load_rx  = 1'b0;
    commit   = 1'b0;

    case (state_q)
      S_EMPTY: begin
        load_rx = rx_pkt_start;
      end
      S_RX: begin
        if (rx_pkt_start) begin
          load_rx = 1'b1;
        end else begin
          if (rx_data_put) begin
            if (wr_ptr_q == MAX_PTR) begin
              ovf_d = 1'b1;
            end else begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
          end
          if (rx_pkt_end) begin
            state_d = S_EMPTY;
            if (rx_pkt_valid && !ovf_d) begin
              if (setup_q) begin
                hs_d   = HS_ACK;
                commit = 1'b1;
              end else if (out_ep_stall) begin
                hs_d = HS_STALL;
              end else begin
                hs_d   = HS_ACK;
                commit = !dup;
              end
            end
          end
        end
      end
      S_FULL: begin
        if (rx_pkt_start) begin
          // A drained buffer may take the new packet directly; SETUP always flushes.
          if (rx_setup || !avail) begin
            load_rx = 1'b1;
          end else begin
            state_d = S_RX_DISCARD;
          end
        end else if (!avail) begin
          state_d = S_EMPTY;
        end
        if (out_ep_req && out_ep_data_get && avail && !load_rx) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      S_RX_DISCARD: begin
        if (rx_pkt_start && rx_setup) begin
          load_rx = 1'b1;
        end else if (rx_pkt_end) begin
          state_d = S_FULL;
          if (rx_pkt_valid) begin
            hs_d = out_ep_stall ? HS_STALL : HS_NAK;
          end
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    if (load_rx) begin
      state_d  = S_RX;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      len_d    = '0;
      ovf_d    = 1'b0;
      setup_d  = rx_setup;
    end

    if (commit) begin
      state_d  = S_FULL;
      len_d    = wr_ptr_d;
      rd_ptr_d = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      setup_q  <= 1'b0;
      hs_q     <= HS_NONE;
      acked_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      setup_q  <= setup_d;
      hs_q     <= hs_d;
      acked_q  <= commit;
    end
  end

  usb_ep_buffer_ram #(
    .DEPTH (MAX_PKT_SIZE),
    .AW    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[RAM_AW-1:0]),
    .wdata_i (rx_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[RAM_AW-1:0]),
    .rdata_o (out_ep_data)
  );

  assign hs_ack            = (hs_q == HS_ACK);
  assign hs_nak            = (hs_q == HS_NAK);
  assign hs_stall          = (hs_q == HS_STALL);
  assign out_ep_acked      = acked_q;
  assign out_ep_grant      = (state_q == S_FULL) && out_ep_req;
  assign out_ep_data_avail = (state_q == S_FULL) && avail;
  assign out_ep_setup      = (state_q == S_FULL) && setup_q;

endmodule
